// File: rtl/cmd_stim_sequencer.sv
// ============================================================================
//  Module   : cmd_stim_sequencer
//  Purpose  : Cycle-accurate stimulus sequencer. Drives N_CH pulse/level
//             channels with programmable per-channel delay and width, repeats
//             the sequence cfg_repeat extra times with idle gaps, and waits
//             for a DUT completion handshake (with optional timeout) after
//             each run. Abortable from any state.
//  Ports    : clock, reset (async, active low)
//             start, abort, dut_done            - control / handshake inputs
//             cfg_delay, cfg_width, cfg_repeat  - sequence configuration
//             stim_out                          - stimulus channels
//             busy, done, timeout, run_idx      - status outputs
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_stim_sequencer #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_CH*CNT_W-1:0] cfg_delay,
    input  logic [N_CH*CNT_W-1:0] cfg_width,
    input  logic [7:0]            cfg_repeat,
    input  logic                  dut_done,
    output logic [N_CH-1:0]       stim_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [7:0]            run_idx
);

    // One extra bit so delay+width never wraps.
    localparam int T_W = CNT_W + 1;
    localparam int W_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int G_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [T_W-1:0]        r_t, w_t_nxt;
    logic [W_W-1:0]        r_w, w_w_nxt;
    logic [G_W-1:0]        r_gap, w_gap_nxt;
    logic                  r_seen, w_seen_nxt;
    logic [N_CH*CNT_W-1:0] r_delay, r_width;
    logic [7:0]            r_repeat;
    logic [N_CH-1:0]       r_stim, w_stim_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic [7:0]            r_run_idx, w_run_idx_nxt;
    logic                  w_accept;

    // Outputs are computed one cycle ahead. On the accepting edge the shadow
    // registers are still being loaded, so the first RUN cycle must be
    // evaluated from the live cfg inputs instead.
    logic [N_CH*CNT_W-1:0] w_src_delay, w_src_width;
    assign w_src_delay = w_accept ? cfg_delay : r_delay;
    assign w_src_width = w_accept ? cfg_width : r_width;

    logic [T_W-1:0]  w_end [N_CH];
    logic [N_CH-1:0] w_hold;
    logic [N_CH-1:0] w_stim_run;
    logic [T_W-1:0]  w_max_end;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [T_W-1:0] w_d, w_wd, w_sd, w_swd;
            assign w_d   = {1'b0, r_delay[gi*CNT_W +: CNT_W]};
            assign w_wd  = {1'b0, r_width[gi*CNT_W +: CNT_W]};
            assign w_sd  = {1'b0, w_src_delay[gi*CNT_W +: CNT_W]};
            assign w_swd = {1'b0, w_src_width[gi*CNT_W +: CNT_W]};

            // Width 0 means the channel is a level that holds until WAIT exit.
            assign w_hold[gi] = (w_wd == '0);
            assign w_end[gi]  = w_hold[gi] ? w_d : (w_d + w_wd - T_W'(1));

            assign w_stim_run[gi] = (w_t_nxt >= w_sd) &&
                                    ((w_swd == '0) || (w_t_nxt < (w_sd + w_swd)));
        end
    endgenerate

    always_comb begin
        w_max_end = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_end[k] > w_max_end) w_max_end = w_end[k];
        end
    end

    logic w_to_hit;
    logic w_done_in;
    assign w_to_hit  = (TIMEOUT_CYC != 0) && (r_w == W_W'(TIMEOUT_CYC - 1));
    assign w_done_in = dut_done || r_seen;

    always_comb begin
        w_state_nxt   = r_state;
        w_t_nxt       = r_t;
        w_w_nxt       = r_w;
        w_gap_nxt     = r_gap;
        w_seen_nxt    = r_seen;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = r_timeout;
        w_run_idx_nxt = r_run_idx;
        w_accept      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = S_RUN;
                    w_t_nxt       = '0;
                    w_seen_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_run_idx_nxt = '0;
                end
            end
            S_RUN: begin
                if (dut_done) w_seen_nxt = 1'b1;
                if (r_t == w_max_end) begin
                    w_state_nxt = S_WAIT;
                    w_w_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + T_W'(1);
                end
            end
            S_WAIT: begin
                if (w_done_in || w_to_hit) begin
                    // A handshake in the expiry cycle takes precedence.
                    if (!w_done_in) w_timeout_nxt = 1'b1;
                    if (r_run_idx < r_repeat) begin
                        w_run_idx_nxt = r_run_idx + 8'd1;
                        w_state_nxt   = S_GAP;
                        w_gap_nxt     = '0;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_w_nxt = r_w + W_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == G_W'(GAP_CYC - 1)) begin
                    w_state_nxt = S_RUN;
                    w_t_nxt     = '0;
                    w_seen_nxt  = 1'b0;
                end else begin
                    w_gap_nxt = r_gap + G_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides everything; status registers keep their values.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_done_nxt    = 1'b0;
            w_timeout_nxt = r_timeout;
            w_run_idx_nxt = r_run_idx;
        end
    end

    always_comb begin
        w_stim_nxt = '0;
        case (w_state_nxt)
            S_RUN:   w_stim_nxt = w_stim_run;
            S_WAIT:  w_stim_nxt = w_hold;
            default: w_stim_nxt = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_w       <= '0;
            r_gap     <= '0;
            r_seen    <= 1'b0;
            r_delay   <= '0;
            r_width   <= '0;
            r_repeat  <= '0;
            r_stim    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_run_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_t       <= w_t_nxt;
            r_w       <= w_w_nxt;
            r_gap     <= w_gap_nxt;
            r_seen    <= w_seen_nxt;
            r_stim    <= w_stim_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_run_idx <= w_run_idx_nxt;
            if (w_accept) begin
                r_delay  <= cfg_delay;
                r_width  <= cfg_width;
                r_repeat <= cfg_repeat;
            end
        end
    end

    assign stim_out = r_stim;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign timeout  = r_timeout;
    assign run_idx  = r_run_idx;

endmodule

`default_nettype wire

// File: tb/tb_cmd_stim_sequencer.sv
// ============================================================================
//  Module   : tb_cmd_stim_sequencer
//  Purpose  : Self-checking bench for cmd_stim_sequencer. For each sequence an
//             expected per-cycle trace (outputs plus the inputs to drive) is
//             built from the behavioural rules, then replayed on the DUT.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmd_stim_sequencer;

    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int TO  = 16;
    localparam int GAP = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NC*CW-1:0]  cfg_delay = '0;
    logic [NC*CW-1:0]  cfg_width = '0;
    logic [7:0]        cfg_repeat = '0;
    logic              dut_done = 1'b0;
    logic [NC-1:0]     stim_out;
    logic              busy, done, timeout;
    logic [7:0]        run_idx;

    cmd_stim_sequencer #(
        .N_CH(NC), .CNT_W(CW), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_repeat(cfg_repeat),
        .dut_done(dut_done), .stim_out(stim_out), .busy(busy), .done(done),
        .timeout(timeout), .run_idx(run_idx)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          dd;
        logic          ab;
        logic          st;
        logic [NC-1:0] stim;
        logic          busy;
        logic          done;
        logic          to;
        logic [7:0]    ridx;
    } ent_t;

    ent_t tr[$];
    ent_t last_e;

    int vectors = 0;
    int miscompares = 0;

    // Sequence description
    int d[NC];
    int w[NC];
    int rep;
    int run_dd[3];    // run-time t at which dut_done pulses, -1 none
    int wait_dd[3];   // wait-cycle index at which dut_done pulses, -1 none
    int abort_run;    // -1 none
    int abort_t;
    int st_prob;      // ignored-start chance per busy cycle, in 1/16 units

    task automatic chk(input string tag, input int cyc, input ent_t e);
        vectors++;
        assert ({stim_out, busy, done, timeout, run_idx} ===
                {e.stim, e.busy, e.done, e.to, e.ridx})
        else begin
            miscompares++;
            $error("FAIL %s cyc=%0d got stim=%b busy=%b done=%b to=%b ridx=%0d exp stim=%b busy=%b done=%b to=%b ridx=%0d",
                   tag, cyc, stim_out, busy, done, timeout, run_idx,
                   e.stim, e.busy, e.done, e.to, e.ridx);
        end
    endtask

    task automatic build();
        ent_t e;
        bit   to_f = 1'b0;
        int   abort_at = -1;
        tr.delete();
        for (int r = 0; r <= rep; r++) begin
            int m = 0;
            int len;
            bit to_exit;
            int rdd;
            logic [NC-1:0] hm = '0;
            for (int i = 0; i < NC; i++) begin
                int en = (w[i] == 0) ? d[i] : d[i] + w[i] - 1;
                if (en > m) m = en;
                hm[i] = (w[i] == 0);
            end
            rdd = (run_dd[r] > m) ? m : run_dd[r];
            if (abort_run == r) abort_at = tr.size() + ((abort_t > m) ? m : abort_t);
            for (int t = 0; t <= m; t++) begin
                e = '0;
                for (int i = 0; i < NC; i++)
                    e.stim[i] = (t >= d[i]) && ((w[i] == 0) || (t < d[i] + w[i]));
                e.busy = 1'b1; e.to = to_f; e.ridx = 8'(r);
                e.dd = (t == rdd);
                tr.push_back(e);
            end
            if (rdd >= 0) begin
                len = 1; to_exit = 1'b0;
            end else if (wait_dd[r] >= 0 && wait_dd[r] < TO) begin
                len = wait_dd[r] + 1; to_exit = 1'b0;
            end else begin
                len = TO; to_exit = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                e = '0;
                e.stim = hm; e.busy = 1'b1; e.to = to_f; e.ridx = 8'(r);
                e.dd = (rdd < 0) && (k == wait_dd[r]);
                tr.push_back(e);
            end
            if (to_exit) to_f = 1'b1;
            if (r < rep) begin
                for (int g = 0; g < GAP; g++) begin
                    e = '0; e.busy = 1'b1; e.to = to_f; e.ridx = 8'(r + 1);
                    tr.push_back(e);
                end
            end else begin
                e = '0; e.done = 1'b1; e.to = to_f; e.ridx = 8'(rep);
                tr.push_back(e);
            end
        end
        if (abort_at >= 0 && abort_at < tr.size() - 1) begin
            ent_t a;
            while (tr.size() > abort_at + 1) void'(tr.pop_back());
            tr[abort_at].ab = 1'b1;
            a = '0; a.to = tr[abort_at].to; a.ridx = tr[abort_at].ridx;
            tr.push_back(a);
        end
        for (int k = 0; k < 2; k++) begin
            e = '0; e.to = tr[tr.size()-1].to; e.ridx = tr[tr.size()-1].ridx;
            tr.push_back(e);
        end
        for (int k = 0; k < tr.size(); k++)
            if (tr[k].busy && ($urandom_range(0, 15) < st_prob)) tr[k].st = 1'b1;
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < NC; i++) begin
            cfg_delay[i*CW +: CW] = CW'(d[i]);
            cfg_width[i*CW +: CW] = CW'(w[i]);
        end
        cfg_repeat = 8'(rep);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic run_seq(input string tag);
        build();
        drive_cfg();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int idx = 0; idx < tr.size(); idx++) begin
            chk(tag, idx, tr[idx]);
            dut_done = tr[idx].dd;
            abort    = tr[idx].ab;
            if (tr[idx].st) begin
                start      = 1'b1;
                cfg_delay  = $urandom;
                cfg_width  = $urandom;
                cfg_repeat = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        dut_done = 1'b0; abort = 1'b0; start = 1'b0;
        last_e = tr[tr.size()-1];
    endtask

    task automatic clear_seq();
        rep = 0; abort_run = -1; abort_t = 0; st_prob = 0;
        for (int r = 0; r < 3; r++) begin run_dd[r] = -1; wait_dd[r] = -1; end
    endtask

    initial begin
        ent_t z;
        z = '0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", 0, z);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_reset", 0, z);

        // Directed: mixed pulse/level channels, dut_done 3 cycles into WAIT
        clear_seq();
        d = '{0, 3, 5, 2}; w = '{0, 4, 1, 0}; wait_dd[0] = 3;
        run_seq("basic");

        // Directed: three runs with gaps, one done at the end
        clear_seq();
        rep = 2; wait_dd = '{2, 2, 2};
        run_seq("repeat");

        // Directed: timeout with no handshake
        clear_seq();
        d = '{1, 0, 2, 3}; w = '{2, 0, 1, 1};
        run_seq("timeout");

        // Directed: handshake in the expiry cycle wins; start clears timeout
        clear_seq();
        wait_dd[0] = TO - 1;
        run_seq("to_boundary");

        // Directed: early handshake during RUN, ignored starts mid-run
        clear_seq();
        run_dd[0] = 1; st_prob = 6;
        run_seq("early_done");

        // Directed: abort at t=4 of run 1 of 3
        clear_seq();
        d = '{0, 3, 5, 2}; w = '{0, 4, 1, 0};
        rep = 2; wait_dd = '{1, 1, 1}; abort_run = 1; abort_t = 4;
        run_seq("abort");

        // Directed: start and abort together in IDLE
        start = 1'b1; abort = 1'b1; drive_cfg();
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("start_abort_idle", k, last_e);
            @(negedge clock);
        end

        // Directed: maximum delay and width, no counter wrap
        clear_seq();
        d = '{255, 0, 0, 0}; w = '{255, 1, 1, 1}; wait_dd[0] = 0;
        run_seq("max_cnt");

        // Randomized sequences
        for (int it = 0; it < 25; it++) begin
            clear_seq();
            for (int i = 0; i < NC; i++) begin
                d[i] = $urandom_range(0, 6);
                w[i] = $urandom_range(0, 5);
            end
            rep = $urandom_range(0, 2);
            for (int r = 0; r < 3; r++) begin
                case ($urandom_range(0, 3))
                    0:       run_dd[r]  = $urandom_range(0, 8);
                    1, 2:    wait_dd[r] = $urandom_range(0, 20);
                    default: ;
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                abort_run = $urandom_range(0, rep);
                abort_t   = $urandom_range(0, 10);
            end
            st_prob = $urandom_range(0, 3);
            run_seq($sformatf("rand%0d", it));
        end

        // Asynchronous reset in the middle of a run with outputs high
        clear_seq();
        d = '{255, 0, 0, 0}; w = '{255, 0, 0, 0}; wait_dd[0] = 0;
        drive_cfg();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        begin
            ent_t h;
            h = '0; h.stim = 4'b1110; h.busy = 1'b1;
            chk("pre_reset_high", 0, h);
        end
        #2 reset = 1'b0;
        #1 chk("async_reset", 0, z);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_reset_idle", k, z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
